pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Consumer side of the PC+4 incrementer: holds the architectural program counter, and each cycle takes in
//  PC_ADDED (PC+4) from the incrementer. Selects next PC among sequential, branch target and jump target,
//  and feeds PC back to the incrementer and instruction memory. Freezes on memory busywait.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC value loaded on RESET
//  OFFSET_W      8              width of signed word offset from instruction immediate
//  PC_LIMIT      32'h0000_03FC  highest legal fetch address (used only with PC_ALIGN_CHECK_EN)
// PORTS
//  CLK            in   1         system clock, all state updates on posedge
//  RESET          in   1         synchronous, active-high
//  PC_ADDED       in   32        PC+4 from incrementer, stable before posedge
//  JUMP           in   1         unconditional jump this instruction
//  BRANCH         in   1         conditional branch (beq) this instruction
//  ZERO           in   1         ALU zero flag
//  OFFSET         in   OFFSET_W  signed word offset (instructions, not bytes)
//  IMEM_BUSYWAIT  in   1         instruction memory/cache not ready
//  DMEM_BUSYWAIT  in   1         data memory/cache not ready
//  PC             out  32        current program counter
//  IMEM_READ      out  1         fetch request for address PC
//  STALL          out  1         high while PC frozen by busywait
//  TRAP           out  1         misaligned/out-of-range PC detected (0 without PC_ALIGN_CHECK_EN)
// BEHAVIOUR
//  - Reset: on posedge CLK with RESET=1: PC<=RESET_VECTOR, state<=BOOT, IMEM_READ=0, STALL=0, TRAP=0.
//    RESET overrides every other input and any state, incl. STALL/HALT mid-operation.
//  - TARGET = PC_ADDED + (sign_extend(OFFSET) << 2), 32-bit modular; wrap-around silently allowed.
//  - NEXT = JUMP ? TARGET : (BRANCH & ZERO) ? TARGET : PC_ADDED. JUMP has priority over BRANCH.
//  - FSM (registered state; outputs decoded from state):
//    BOOT : IMEM_READ=0, PC held. Next cycle -> RUN. (one idle cycle after reset)
//    RUN  : IMEM_READ=1. If IMEM_BUSYWAIT|DMEM_BUSYWAIT -> STALL, PC held;
//           else PC<=NEXT, stay RUN (one PC update per cycle, latency 1 from PC_ADDED to PC).
//    STALL: IMEM_READ=1, STALL=1, PC held. Leave when both busywaits low in same cycle:
//           PC<=NEXT (branch decision sampled at exit edge), -> RUN.
//    HALT : only with PC_ALIGN_CHECK_EN; IMEM_READ=0, TRAP=1, PC held; exits only via RESET.
//  - Busywait rising while BOOT: ignored (no fetch outstanding).
//  - JUMP and BRANCH both high: JUMP taken. BRANCH with ZERO=0: sequential.
//  - OFFSET=0 with JUMP: PC<=PC_ADDED (branch-to-next, legal).
// CONFIGURATION
//  PC_ALIGN_CHECK_EN defined: in RUN/STALL exit, if NEXT[1:0]!=0 or NEXT>PC_LIMIT, PC is NOT updated,
//    state->HALT, TRAP=1 from next cycle.
//  Not defined: no check, HALT unreachable, TRAP tied 0, NEXT always loaded.
// STRUCTURE
//  Shared package pc_defs: state encodings (BOOT/RUN/STALL/HALT), WORD_SHIFT=2, RESET_VECTOR default.
//  One sub-module: pc_target_adder (combinational PC_ADDED + scaled sign-extended OFFSET -> TARGET).
//  FSM, next-PC mux and PC register stay in pc_sequencer.
// TESTING
//  1 RESET 1 cycle, PC_ADDED=PC+4 loop -> PC=0,IMEM_READ=0 one cycle, then 0,4,8,12 per cycle.
//  2 PC=0x10, BRANCH=1,ZERO=1,OFFSET=8'hFE -> PC=0x0C; ZERO=0 -> PC=0x14.
//  3 PC=0x20, JUMP=1,BRANCH=1,ZERO=1,OFFSET=3 -> PC=0x30 (jump priority).
//  4 PC=0x08, IMEM_BUSYWAIT high 5 cycles -> STALL=1, PC=0x08 for 5 cycles, then 0x0C next edge.
//  5 RESET asserted during STALL -> PC=RESET_VECTOR, STALL=0, BOOT next cycle.
//  6 (PC_ALIGN_CHECK_EN) PC=0x3FC, PC_ADDED=0x400 -> TRAP=1, PC stays 0x3FC, IMEM_READ=0 until RESET.

Source files
------------

// File: rtl/pc_defs.sv
// Shared definitions for the program-counter sequencer: FSM state encodings,
// byte scaling of word offsets and the default reset vector.
package pc_defs;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } pc_state_t;

  localparam int          WORD_SHIFT           = 2;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_target_adder.sv
// Branch/jump target: PC+4 plus the sign-extended instruction offset scaled
// from words to bytes. Pure combinational, 32-bit modular arithmetic.
module pc_target_adder
  import pc_defs::*;
#(
  parameter int OFFSET_W = 8
) (
  input  logic                       [31:0] pc_added,
  input  logic signed [OFFSET_W-1:0]        offset,
  output logic                       [31:0] target
);

  logic signed [31:0] offset_ext;
  logic        [31:0] offset_bytes;

  assign offset_ext   = {{(32-OFFSET_W){offset[OFFSET_W-1]}}, offset};
  assign offset_bytes = offset_ext <<< WORD_SHIFT;
  assign target       = pc_added + offset_bytes;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter register, next-PC selection and fetch-control FSM.
// Optional PC range/alignment trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer
  import pc_defs::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int          OFFSET_W     = 8,
  parameter logic [31:0] PC_LIMIT     = 32'h0000_03FC
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                [31:0] PC_ADDED,
  input  logic                       JUMP,
  input  logic                       BRANCH,
  input  logic                       ZERO,
  input  logic signed [OFFSET_W-1:0] OFFSET,
  input  logic                       IMEM_BUSYWAIT,
  input  logic                       DMEM_BUSYWAIT,
  output logic                [31:0] PC,
  output logic                       IMEM_READ,
  output logic                       STALL,
  output logic                       TRAP
);

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  pc_state_t   state;
  logic [31:0] target;
  logic [31:0] next_pc;
  logic        busy;
  logic        take_target;
  logic        halt_req;

  pc_target_adder #(
    .OFFSET_W (OFFSET_W)
  ) u_target (
    .pc_added (PC_ADDED),
    .offset   (OFFSET),
    .target   (target)
  );

  assign busy        = IMEM_BUSYWAIT | DMEM_BUSYWAIT;
  assign take_target = JUMP | (BRANCH & ZERO);
  assign next_pc     = take_target ? target : PC_ADDED;
  // With the check compiled out this folds to 0, so HALT is never entered and TRAP stays low.
  assign halt_req    = ALIGN_CHECK &&
                       ((next_pc[1:0] != 2'b00) || (next_pc > PC_LIMIT));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_BOOT;
      PC        <= RESET_VECTOR;
      IMEM_READ <= 1'b0;
      STALL     <= 1'b0;
      TRAP      <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          state     <= ST_RUN;
          IMEM_READ <= 1'b1;
          STALL     <= 1'b0;
          TRAP      <= 1'b0;
        end
        // RUN and STALL exit share one path: the branch decision is taken at the edge PC moves.
        ST_RUN, ST_STALL: begin
          if (busy) begin
            state     <= ST_STALL;
            IMEM_READ <= 1'b1;
            STALL     <= 1'b1;
            TRAP      <= 1'b0;
          end else if (halt_req) begin
            state     <= ST_HALT;
            IMEM_READ <= 1'b0;
            STALL     <= 1'b0;
            TRAP      <= 1'b1;
          end else begin
            state     <= ST_RUN;
            PC        <= next_pc;
            IMEM_READ <= 1'b1;
            STALL     <= 1'b0;
            TRAP      <= 1'b0;
          end
        end
        ST_HALT: begin
          state     <= ST_HALT;
          IMEM_READ <= 1'b0;
          STALL     <= 1'b0;
          TRAP      <= 1'b1;
        end
        default: begin
          state     <= ST_BOOT;
          IMEM_READ <= 1'b0;
          STALL     <= 1'b0;
          TRAP      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model queues the expected
// PC/control outputs per cycle, compared one cycle later against the DUT.
module tb_pc_sequencer;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] LIMIT = 32'h0000_03FC;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] PC_ADDED = '0;
  logic        JUMP = 1'b0, BRANCH = 1'b0, ZERO = 1'b0;
  logic [7:0]  OFFSET = '0;
  logic        IMEM_BUSYWAIT = 1'b0, DMEM_BUSYWAIT = 1'b0;
  logic [31:0] PC;
  logic        IMEM_READ, STALL, TRAP;

  pc_sequencer #(
    .RESET_VECTOR (RV),
    .OFFSET_W     (8),
    .PC_LIMIT     (LIMIT)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .PC_ADDED      (PC_ADDED),
    .JUMP          (JUMP),
    .BRANCH        (BRANCH),
    .ZERO          (ZERO),
    .OFFSET        (OFFSET),
    .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
    .DMEM_BUSYWAIT (DMEM_BUSYWAIT),
    .PC            (PC),
    .IMEM_READ     (IMEM_READ),
    .STALL         (STALL),
    .TRAP          (TRAP)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic        ir;
    logic        st;
    logic        tr;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // model state: 0 boot, 1 run, 2 stall, 3 halt
  logic [31:0] m_pc = RV;
  int          m_st = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [31:0] pa, input logic j, input logic b,
                      input logic z, input logic [7:0] off, input logic ib, input logic db);
    logic [31:0] tgt, nxt;
    logic        bad;
    exp_t        e;
    RESET = rst; PC_ADDED = pa; JUMP = j; BRANCH = b; ZERO = z;
    OFFSET = off; IMEM_BUSYWAIT = ib; DMEM_BUSYWAIT = db;
    tgt = pa + {{22{off[7]}}, off, 2'b00};
    nxt = j ? tgt : ((b && z) ? tgt : pa);
    bad = ALIGN && ((nxt[1:0] != 2'b00) || (nxt > LIMIT));
    if (rst) begin
      m_pc = RV; m_st = 0;
    end else begin
      case (m_st)
        0: m_st = 1;
        1, 2: begin
          if (ib || db) m_st = 2;
          else if (bad) m_st = 3;
          else begin m_pc = nxt; m_st = 1; end
        end
        default: m_st = 3;
      endcase
    end
    e.pc = m_pc;
    e.ir = (m_st == 1) || (m_st == 2);
    e.st = (m_st == 2);
    e.tr = (m_st == 3);
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    check("pc", PC, e.pc);
    check("imem_read", {31'b0, IMEM_READ}, {31'b0, e.ir});
    check("stall", {31'b0, STALL}, {31'b0, e.st});
    check("trap", {31'b0, TRAP}, {31'b0, e.tr});
  endtask

  task automatic seq();
    step(1'b0, m_pc + 32'd4, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    #1;
    // reset, then boot idle cycle with a busywait that must be ignored
    step(1'b1, 32'h0, 0, 0, 0, 8'h00, 1'b0, 1'b0);
    check("rst_pc", PC, 32'h0);
    check("rst_imem_read", {31'b0, IMEM_READ}, 32'h0);
    step(1'b0, 32'h4, 0, 0, 0, 8'h00, 1'b1, 1'b0);
    check("boot_pc", PC, 32'h0);
    check("boot_exit_read", {31'b0, IMEM_READ}, 32'h1);
    check("boot_no_stall", {31'b0, STALL}, 32'h0);
    seq(); check("seq_4", PC, 32'h4);
    seq(); check("seq_8", PC, 32'h8);

    // five cycles of instruction busywait at PC=8
    for (int i = 0; i < 5; i++) begin
      step(1'b0, m_pc + 32'd4, 0, 0, 0, 8'h00, 1'b1, 1'b0);
      check("stall_flag", {31'b0, STALL}, 32'h1);
      check("stall_pc", PC, 32'h8);
    end
    seq(); check("stall_exit_pc", PC, 32'hC);

    // data busywait, jump decided at the exit edge
    step(1'b0, 32'h10, 0, 0, 0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 32'h10, 1, 0, 0, 8'h01, 1'b0, 1'b0);
    check("dstall_jump", PC, 32'h14);

    // branch taken backwards / not taken
    step(1'b0, 32'h10, 0, 0, 0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 32'h14, 0, 1, 1, 8'hFE, 1'b0, 1'b0);
    check("beq_taken", PC, 32'hC);
    step(1'b0, 32'h10, 0, 0, 0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 32'h14, 0, 1, 0, 8'hFE, 1'b0, 1'b0);
    check("beq_not_taken", PC, 32'h14);

    // jump priority and zero-offset jump
    step(1'b0, 32'h20, 0, 0, 0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 32'h24, 1, 1, 1, 8'h03, 1'b0, 1'b0);
    check("jump_prio", PC, 32'h30);
    step(1'b0, 32'h34, 1, 0, 0, 8'h00, 1'b0, 1'b0);
    check("jump_off0", PC, 32'h34);

    // reset in the middle of a stall
    step(1'b0, 32'h38, 0, 0, 0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 32'h38, 0, 0, 0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 32'h38, 0, 0, 0, 8'h00, 1'b1, 1'b0);
    check("rst_stall_pc", PC, RV);
    check("rst_stall_flag", {31'b0, STALL}, 32'h0);
    step(1'b0, 32'h4, 0, 0, 0, 8'h00, 1'b0, 1'b0);
    check("rst_then_run_pc", PC, RV);

    // randomised traffic with small forward offsets
    for (int i = 0; i < 40; i++) begin
      step(1'b0, m_pc + 32'd4, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0));
    end
    step(1'b0, m_pc + 32'd4, 0, 0, 0, 8'h00, 1'b0, 1'b0);

`ifndef PC_ALIGN_CHECK_EN
    // modular wrap of the target is legal without the check
    step(1'b0, 32'h0, 1, 0, 0, 8'hFF, 1'b0, 1'b0);
    check("wrap_pc", PC, 32'hFFFF_FFFC);
    check("wrap_no_trap", {31'b0, TRAP}, 32'h0);
`else
    // fetch beyond PC_LIMIT traps and holds until reset
    step(1'b1, 32'h0, 0, 0, 0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 32'h4, 0, 0, 0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 32'h3FC, 0, 0, 0, 8'h00, 1'b0, 1'b0);
    check("limit_pc", PC, 32'h3FC);
    step(1'b0, 32'h400, 0, 0, 0, 8'h00, 1'b0, 1'b0);
    check("trap_set", {31'b0, TRAP}, 32'h1);
    check("trap_pc_held", PC, 32'h3FC);
    check("trap_no_read", {31'b0, IMEM_READ}, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h8, 0, 0, 0, 8'h00, 1'b0, 1'b0);
    check("trap_sticky", {31'b0, TRAP}, 32'h1);
    step(1'b1, 32'h0, 0, 0, 0, 8'h00, 1'b0, 1'b0);
    check("trap_cleared", {31'b0, TRAP}, 32'h0);
    step(1'b0, 32'h4, 0, 0, 0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 32'h6, 0, 0, 0, 8'h00, 1'b0, 1'b0);
    check("misalign_trap", {31'b0, TRAP}, 32'h1);
    check("misalign_pc", PC, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
